// File: rtl/addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
// Provides the FSM state encoding and the operating-mode constants.
// Optional overflow output is enabled by defining SERIAL_ADDSUB_OVF_EN.
package addsub_pkg;

    // FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Mode values carried on c0
    localparam logic MODE_ADD = 1'b1;
    localparam logic MODE_SUB = 1'b0;

endpackage : addsub_pkg

// File: rtl/serial_addsub8_fa1.sv
// fa1: combinational 1-bit full adder.
// Ports: a, b, ci (inputs) -> s (sum), co (carry out).
module fa1 (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule : fa1

// File: rtl/serial_addsub8.sv
// serial_addsub8: bit-serial adder/subtractor, one bit per clock, LSB first.
// c0=1 adds ({c1,s} = a+b); c0=0 subtracts (s = a-b, c1 = 1 means no borrow).
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   start         request, sampled only in IDLE; a, b, c0 captured with it
//   busy          high while the operation is in flight
//   done          one-cycle pulse when s/c1 carry a new result
//   s, c1         result and carry/not-borrow; hold the last completed value
//   ovf           signed overflow, only when SERIAL_ADDSUB_OVF_EN is defined
module serial_addsub8
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c0,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c1
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t             state, state_next;
    logic [WIDTH-1:0]   a_sh, b_sh, r_sh;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               load_c, step_c, last_c;
    logic               sum_c, co_c;

    // Single full-adder cell shared across all bit positions
    fa1 u_fa1 (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (sum_c),
        .co (co_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state and datapath control
    always_comb begin
        state_next = state;
        load_c     = 1'b0;
        step_c     = 1'b0;
        last_c     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    load_c     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                step_c = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    last_c     = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand/result shift registers, carry and bit counter.
    // Subtract is a + ~b + 1: invert B at load and seed the carry with 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (load_c) begin
            a_sh  <= a;
            b_sh  <= (c0 == MODE_ADD) ? b : ~b;
            carry <= ~c0;
            cnt   <= '0;
        end else if (step_c) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            r_sh  <= {sum_c, r_sh[WIDTH-1:1]};
            carry <= co_c;
            cnt   <= cnt + CNT_W'(1);
        end
    end

    // Registered outputs; s/c1 only move on the final bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            s    <= '0;
            c1   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf  <= 1'b0;
`endif
        end else begin
            busy <= (state_next == ST_RUN);
            done <= (state_next == ST_DONE);
            if (last_c) begin
                s  <= {sum_c, r_sh[WIDTH-1:1]};
                c1 <= co_c;
`ifdef SERIAL_ADDSUB_OVF_EN
                // On the last step, carry holds the carry into the MSB
                ovf <= carry ^ co_c;
`endif
            end
        end
    end

endmodule : serial_addsub8

// File: tb/tb_serial_addsub8.sv
// Directed testbench for serial_addsub8 (8-bit build).
module tb_serial_addsub8;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       c0;
    logic       busy, done;
    logic [7:0] s;
    logic       c1;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic       ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    serial_addsub8 #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c0    (c0),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .c1    (c1)
`ifdef SERIAL_ADDSUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for done on negedges; counts cycles and busy-high cycles.
    task automatic wait_done(input bit drop_start, output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        while (cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (drop_start && cyc == 1) start = 1'b0;
            if (done === 1'b1) break;
            if (busy === 1'b1) bcnt++;
        end
        if (done !== 1'b1) check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic launch(input logic [7:0] ta, input logic [7:0] tb_, input logic tc);
        @(negedge clk);
        a     = ta;
        b     = tb_;
        c0    = tc;
        start = 1'b1;
    endtask

    // Operation with full result check against a bench-computed model
    task automatic op_check(input logic [7:0] ta, input logic [7:0] tb_, input logic tc);
        int cyc, bcnt;
        logic [8:0] e;
        launch(ta, tb_, tc);
        wait_done(1'b1, cyc, bcnt);
        e = tc ? ({1'b0, ta} + {1'b0, tb_}) : ({1'b0, ta} + {1'b0, ~tb_} + 9'd1);
        check("sweep_s", 32'(s), 32'(e[7:0]));
        check("sweep_c1", 32'(c1), 32'(e[8]));
`ifdef SERIAL_ADDSUB_OVF_EN
        if (tc) check("sweep_ovf", 32'(ovf), 32'((ta[7] == tb_[7]) && (e[7] != ta[7])));
        else    check("sweep_ovf", 32'(ovf), 32'((ta[7] != tb_[7]) && (e[7] != ta[7])));
`endif
    endtask

    initial begin
        int cyc, bcnt, dcnt;
        logic [7:0] vals [0:21];

        rst_n = 1'b0;
        start = 1'b0;
        a = '0; b = '0; c0 = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_c1", 32'(c1), 32'd0);
        rst_n = 1'b1;

        // Add 100+27: 8 busy cycles, done seen 9 cycles after start edge
        launch(8'd100, 8'd27, 1'b1);
        wait_done(1'b1, cyc, bcnt);
        check("add_latency", 32'(cyc), 32'd9);
        check("add_busy_cycles", 32'(bcnt), 32'd8);
        check("add_busy_at_done", 32'(busy), 32'd0);
        check("add_s", 32'(s), 32'd127);
        check("add_c1", 32'(c1), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("s_holds", 32'(s), 32'd127);

        // Add with wrap
        launch(8'd200, 8'd100, 1'b1);
        wait_done(1'b1, cyc, bcnt);
        check("wrap_s", 32'(s), 32'd44);
        check("wrap_c1", 32'(c1), 32'd1);

`ifdef SERIAL_ADDSUB_OVF_EN
        launch(8'd100, 8'd100, 1'b1);
        wait_done(1'b1, cyc, bcnt);
        check("ovf_s", 32'(s), 32'd200);
        check("ovf_flag", 32'(ovf), 32'd1);
`endif

        // Subtract
        launch(8'd50, 8'd20, 1'b0);
        wait_done(1'b1, cyc, bcnt);
        check("sub_s", 32'(s), 32'd30);
        check("sub_c1", 32'(c1), 32'd1);
        launch(8'd20, 8'd50, 1'b0);
        wait_done(1'b1, cyc, bcnt);
        check("sub_borrow_s", 32'(s), 32'd226);
        check("sub_borrow_c1", 32'(c1), 32'd0);

        // Start held high, operands toggled mid-operation
        launch(8'd10, 8'd5, 1'b1);
        cyc  = 0;
        dcnt = 0;
        while (cyc < 30 && done !== 1'b1) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) dcnt++;
            else begin
                a = ~a;
                b = ~b;
                c0 = ~c0;
            end
        end
        check("hold_done_count", 32'(dcnt), 32'd1);
        check("hold_s", 32'(s), 32'd15);
        check("hold_c1", 32'(c1), 32'd0);
        a = 8'd3; b = 8'd4; c0 = 1'b1;
        @(negedge clk);
        check("hold_idle_done", 32'(done), 32'd0);
        check("hold_idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("hold_reaccept_busy", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done(1'b0, cyc, bcnt);
        check("hold_second_latency", 32'(cyc), 32'd8);
        check("hold_second_s", 32'(s), 32'd7);

        // Leave a nonzero result in place, then abort mid-operation
        launch(8'd20, 8'd50, 1'b0);
        wait_done(1'b1, cyc, bcnt);
        launch(8'd7, 8'd9, 1'b1);
        repeat (5) @(negedge clk);
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_s", 32'(s), 32'd0);
        check("abort_c1", 32'(c1), 32'd0);
        dcnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        check("abort_no_done", 32'(dcnt), 32'd0);
        check("abort_idle_busy", 32'(busy), 32'd0);
        launch(8'd1, 8'd1, 1'b1);
        wait_done(1'b1, cyc, bcnt);
        check("post_reset_s", 32'(s), 32'd2);
        check("post_reset_c1", 32'(c1), 32'd0);

        // Operand sweep: boundary values plus a spread grid, both modes
        vals = '{8'd0, 8'd1, 8'd2, 8'd17, 8'd34, 8'd51, 8'd68, 8'd85, 8'd102, 8'd119,
                 8'd126, 8'd127, 8'd128, 8'd129, 8'd136, 8'd153, 8'd170, 8'd187,
                 8'd204, 8'd221, 8'd254, 8'd255};
        for (int i = 0; i < 22; i++) begin
            for (int j = 0; j < 22; j++) begin
                op_check(vals[i], vals[j], 1'b1);
                op_check(vals[i], vals[j], 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_serial_addsub8
